dll_replay_buffer: RTL and testbench
====================================

DLL_REPLAY_BUFFER -- requirements
Module: dll_replay_buffer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 32, AXIS data width
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- USER_WIDTH, 1, tuser width
- SLOT_COUNT, 4, stored TLPs, power of two, 2..16
- SLOT_DEPTH, 64, words per slot
- REPLAY_TIMEOUT, 160, replay timer threshold in cycles
- REPLAY_NUM_MAX, 3, replays allowed before error
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, single clock
- rst_i, in, 1, synchronous active-high reset
- s_axis_tdata/tkeep/tvalid/tlast/tuser/tready, in/in/in/in/in/out, DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH/1, new TLP input
- tx_seq_num_i, in, 12, sequence number of the TLP on s_axis, sampled on its first beat
- m_axis_tdata/tkeep/tvalid/tlast/tuser/tready, out/out/out/out/out/in, same widths, TLP output, new and replayed
- ack_nack_vld_i, in, 1, ACK/NAK DLLP strobe
- ack_nack_i, in, 1, 1 = ACK, 0 = NAK
- ack_seq_num_i, in, 12, AckNak_Seq_Num
- retry_available_o, out, 1, at least one free slot
- replay_active_o, out, 1, replay in progress
- retry_err_o, out, 1, sticky REPLAY_NUM rollover or slot overflow
- occupancy_o, out, $clog2(SLOT_COUNT)+1, unacked slot count

Function
REQ-003 Slots SHALL form a ring with head (oldest unacked), tail and count; per slot: 12-bit seq, word length, data/keep/user/last words.
REQ-004 In FORWARD mode, s_axis SHALL pass to m_axis combinationally with zero latency; s_axis_tready = m_axis_tready AND NOT full AND NOT replaying (and no replay pending at a TLP boundary).
REQ-005 Each accepted beat SHALL be written to the tail slot; the slot SHALL commit (tail++, count++) on the tlast handshake.
REQ-006 Beats beyond SLOT_DEPTH SHALL still be forwarded but not stored; the slot SHALL keep its last stored word as its tlast; retry_err_o SHALL be set.
REQ-007 ACK or NAK SHALL latch ack_seq_num_i; the purge engine SHALL free one head slot per cycle while count>0 and ((ack_seq - head_seq) mod 4096) < 2048.
REQ-008 Freeing at least one slot SHALL clear the replay timer and REPLAY_NUM.
REQ-009 The replay timer SHALL count while count>0 and FSM is FORWARD; it SHALL hold at 0 when count==0.
REQ-010 Replay SHALL be requested by a NAK (after its purge completes) or by timer == REPLAY_TIMEOUT; each request SHALL increment 2-bit REPLAY_NUM.
REQ-011 A request made while REPLAY_NUM == REPLAY_NUM_MAX SHALL set retry_err_o, wrap REPLAY_NUM to 0 and still replay.
REQ-012 FSM states SHALL be: FORWARD -> (request, no TLP mid-transfer) REPLAY; FORWARD mid-TLP -> request held pending until that tlast handshake; REPLAY -> FORWARD after the last stored slot's last word handshakes; the timer SHALL restart from 0 on exit.
REQ-013 REPLAY SHALL stream every slot head..tail-1 in order, all stored words, tlast on each slot's final word, honouring m_axis_tready.
REQ-014 ACK/NAK received during REPLAY SHALL only update the latched seq (latest wins); purge SHALL run after REPLAY exits; NAK during REPLAY SHALL NOT start a new replay.
REQ-015 A NAK with count==0 SHALL cause no replay and no REPLAY_NUM change.
REQ-016 Simultaneous slot commit and purge free SHALL update count by the net value.
REQ-017 Sequence comparisons SHALL be modulo 4096 (wrap 4095->0 correct).

Reset
REQ-018 rst_i SHALL clear head, tail, count, timer, REPLAY_NUM, pending flags, retry_err_o; FSM SHALL return to FORWARD; any TLP mid-transfer SHALL be discarded.
REQ-019 After reset: m_axis_tvalid=0, retry_available_o=1, replay_active_o=0, occupancy_o=0; slot memory SHALL NOT be reset.

Configuration
REQ-020 Macro DLL_REPLAY_STATS_EN defined: add output replay_count_o (16 bits, saturating count of replays started, reset 0). Undefined: port and counter absent; behaviour otherwise identical.

Verification
REQ-021 Send seq 0..3 (8 words each), ACK seq 1 -> occupancy 4 then 2, no replay.
REQ-022 Send seq 10,11, NAK seq 10 -> slot 10 freed, seq 11 replayed once (8 words, tlast on word 8), replay_active_o high during it.
REQ-023 One TLP, no ACK, m_axis_tready=1 -> replay starts 160 cycles after commit; 4th timeout sets retry_err_o.
REQ-024 Fill 4 slots -> s_axis_tready=0, retry_available_o=0; ACK newest seq -> slots freed one per cycle, tready returns.
REQ-025 Seq 4094,4095,0 stored, ACK 0 -> all three freed (wrap).
REQ-026 Assert rst_i mid-replay -> next cycle m_axis_tvalid=0, occupancy_o=0, retry_err_o=0.

Source files
------------

// File: rtl/dll_replay_buffer.sv
// Data-link-layer replay buffer: forwards TLPs, keeps a copy of each until it is ACKed, replays on NAK or timeout.
// Defining DLL_REPLAY_STATS_EN adds a saturating replay_count_o output.
module dll_replay_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int KEEP_WIDTH     = DATA_WIDTH/8,
    parameter int USER_WIDTH     = 1,
    parameter int SLOT_COUNT     = 4,
    parameter int SLOT_DEPTH     = 64,
    parameter int REPLAY_TIMEOUT = 160,
    parameter int REPLAY_NUM_MAX = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    input  logic [USER_WIDTH-1:0]         s_axis_tuser,
    output logic                          s_axis_tready,
    input  logic [11:0]                   tx_seq_num_i,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    input  logic                          m_axis_tready,
    input  logic                          ack_nack_vld_i,
    input  logic                          ack_nack_i,
    input  logic [11:0]                   ack_seq_num_i,
    output logic                          retry_available_o,
    output logic                          replay_active_o,
    output logic                          retry_err_o,
    output logic [$clog2(SLOT_COUNT):0]   occupancy_o
`ifdef DLL_REPLAY_STATS_EN
    ,
    output logic [15:0]                   replay_count_o
`endif
);

    localparam int SLOT_W    = $clog2(SLOT_COUNT);
    localparam int CNT_W     = SLOT_W + 1;
    localparam int LEN_W     = $clog2(SLOT_DEPTH + 1);
    localparam int WORD_W    = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH;
    localparam int MEM_DEPTH = SLOT_COUNT * SLOT_DEPTH;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int TMR_W     = $clog2(REPLAY_TIMEOUT + 1);

    typedef enum logic [0:0] {ST_FORWARD, ST_REPLAY} state_t;

    state_t             state_reg;
    logic [SLOT_W-1:0]  head_reg, tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [LEN_W-1:0]   wr_word_reg;
    logic               mid_tlp_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic [1:0]         replay_num_reg;
    logic               replay_pending_reg, nak_pending_reg, ack_seen_reg;
    logic [11:0]        ack_seq_reg;
    logic               retry_err_reg;
    logic [SLOT_W-1:0]  fetch_slot_reg;
    logic [LEN_W-1:0]   fetch_word_reg;
    logic [CNT_W-1:0]   fetch_left_reg;
    logic               fetch_done_reg;
    logic               rep_valid_reg, rep_last_reg;
    logic [WORD_W-1:0]  rd_word_reg;

    logic [WORD_W-1:0]  mem [MEM_DEPTH];
    logic [11:0]        seq_mem [SLOT_COUNT];
    logic [LEN_W-1:0]   len_mem [SLOT_COUNT];

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0] slot,
                                                    input logic [LEN_W-1:0] word);
        return ADDR_W'(slot) * ADDR_W'(SLOT_DEPTH) + ADDR_W'(word);
    endfunction

    logic full, start_gate, fwd_ok, s_hs, commit, wr_en;
    logic start_replay, purge_free, timer_hit, nak_done, replay_req;
    logic fetch_en, fetch_last, rep_exit;
    logic [11:0]       seq_diff;
    logic [LEN_W-1:0]  len_commit;

    // A pending replay blocks new TLPs only once the current TLP has finished.
    assign full          = (count_reg == CNT_W'(SLOT_COUNT));
    assign start_gate    = replay_pending_reg && !mid_tlp_reg;
    assign fwd_ok        = (state_reg == ST_FORWARD) && !full && !start_gate;
    assign s_axis_tready = m_axis_tready && fwd_ok;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign commit        = s_hs && s_axis_tlast;
    assign wr_en         = s_hs && (wr_word_reg < LEN_W'(SLOT_DEPTH));
    assign len_commit    = wr_en ? wr_word_reg + LEN_W'(1) : LEN_W'(SLOT_DEPTH);

    // Head is acknowledged when it lies in the half-space at or behind the latched sequence.
    assign seq_diff     = ack_seq_reg - seq_mem[head_reg];
    assign start_replay = (state_reg == ST_FORWARD) && start_gate;
    assign purge_free   = (state_reg == ST_FORWARD) && !start_gate && ack_seen_reg
                          && (count_reg != '0) && !seq_diff[11];
    assign timer_hit    = (state_reg == ST_FORWARD) && (count_reg != '0)
                          && (timer_reg == TMR_W'(REPLAY_TIMEOUT)) && !purge_free;
    assign nak_done     = (state_reg == ST_FORWARD) && nak_pending_reg && !purge_free;
    assign replay_req   = (timer_hit || (nak_done && count_reg != '0)) && !replay_pending_reg;

    assign fetch_last = (fetch_word_reg == len_mem[fetch_slot_reg] - LEN_W'(1));
    assign fetch_en   = (state_reg == ST_REPLAY) && !fetch_done_reg
                        && (!rep_valid_reg || m_axis_tready);
    assign rep_exit   = (state_reg == ST_REPLAY) && rep_valid_reg && m_axis_tready
                        && rep_last_reg && fetch_done_reg;

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[slot_addr(tail_reg, wr_word_reg)] <= {s_axis_tuser, s_axis_tkeep, s_axis_tdata};
        if (fetch_en)
            rd_word_reg <= mem[slot_addr(fetch_slot_reg, fetch_word_reg)];
        if (s_hs && !mid_tlp_reg)
            seq_mem[tail_reg] <= tx_seq_num_i;
        if (commit)
            len_mem[tail_reg] <= len_commit;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg          <= ST_FORWARD;
            head_reg           <= '0;
            tail_reg           <= '0;
            count_reg          <= '0;
            wr_word_reg        <= '0;
            mid_tlp_reg        <= 1'b0;
            timer_reg          <= '0;
            replay_num_reg     <= '0;
            replay_pending_reg <= 1'b0;
            nak_pending_reg    <= 1'b0;
            ack_seen_reg       <= 1'b0;
            ack_seq_reg        <= '0;
            retry_err_reg      <= 1'b0;
            fetch_slot_reg     <= '0;
            fetch_word_reg     <= '0;
            fetch_left_reg     <= '0;
            fetch_done_reg     <= 1'b0;
            rep_valid_reg      <= 1'b0;
            rep_last_reg       <= 1'b0;
        end else begin
            if (s_hs) begin
                if (s_axis_tlast) begin
                    mid_tlp_reg <= 1'b0;
                    wr_word_reg <= '0;
                    tail_reg    <= tail_reg + SLOT_W'(1);
                end else begin
                    mid_tlp_reg <= 1'b1;
                    if (wr_en)
                        wr_word_reg <= wr_word_reg + LEN_W'(1);
                end
                if (!wr_en)
                    retry_err_reg <= 1'b1;
            end

            count_reg <= count_reg + CNT_W'(commit) - CNT_W'(purge_free);
            if (purge_free)
                head_reg <= head_reg + SLOT_W'(1);

            if (ack_nack_vld_i) begin
                ack_seq_reg  <= ack_seq_num_i;
                ack_seen_reg <= 1'b1;
            end
            if (ack_nack_vld_i && !ack_nack_i && state_reg == ST_FORWARD)
                nak_pending_reg <= 1'b1;
            else if (nak_done)
                nak_pending_reg <= 1'b0;

            if (rep_exit || purge_free || count_reg == '0)
                timer_reg <= '0;
            else if (state_reg == ST_FORWARD && timer_reg != TMR_W'(REPLAY_TIMEOUT))
                timer_reg <= timer_reg + TMR_W'(1);

            if (purge_free) begin
                replay_num_reg <= '0;
            end else if (replay_req) begin
                if (replay_num_reg == 2'(REPLAY_NUM_MAX)) begin
                    replay_num_reg <= '0;
                    retry_err_reg  <= 1'b1;
                end else begin
                    replay_num_reg <= replay_num_reg + 2'd1;
                end
            end

            if (replay_req)
                replay_pending_reg <= 1'b1;
            else if (start_replay)
                replay_pending_reg <= 1'b0;

            case (state_reg)
                ST_FORWARD: begin
                    // Everything may have been purged while the request waited.
                    if (start_replay && count_reg != '0) begin
                        state_reg      <= ST_REPLAY;
                        fetch_slot_reg <= head_reg;
                        fetch_word_reg <= '0;
                        fetch_left_reg <= count_reg;
                        fetch_done_reg <= 1'b0;
                        rep_valid_reg  <= 1'b0;
                    end
                end
                ST_REPLAY: begin
                    if (fetch_en) begin
                        rep_valid_reg <= 1'b1;
                        rep_last_reg  <= fetch_last;
                        if (fetch_last) begin
                            fetch_slot_reg <= fetch_slot_reg + SLOT_W'(1);
                            fetch_word_reg <= '0;
                            fetch_left_reg <= fetch_left_reg - CNT_W'(1);
                            if (fetch_left_reg == CNT_W'(1))
                                fetch_done_reg <= 1'b1;
                        end else begin
                            fetch_word_reg <= fetch_word_reg + LEN_W'(1);
                        end
                    end else if (m_axis_tready) begin
                        rep_valid_reg <= 1'b0;
                    end
                    if (rep_exit) begin
                        state_reg     <= ST_FORWARD;
                        rep_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_FORWARD;
            endcase
        end
    end

    always_comb begin
        if (state_reg == ST_REPLAY) begin
            m_axis_tdata  = rd_word_reg[DATA_WIDTH-1:0];
            m_axis_tkeep  = rd_word_reg[DATA_WIDTH +: KEEP_WIDTH];
            m_axis_tuser  = rd_word_reg[DATA_WIDTH+KEEP_WIDTH +: USER_WIDTH];
            m_axis_tvalid = rep_valid_reg;
            m_axis_tlast  = rep_last_reg;
        end else begin
            m_axis_tdata  = s_axis_tdata;
            m_axis_tkeep  = s_axis_tkeep;
            m_axis_tuser  = s_axis_tuser;
            m_axis_tvalid = s_axis_tvalid && fwd_ok;
            m_axis_tlast  = s_axis_tlast;
        end
    end

    assign retry_available_o = !full;
    assign replay_active_o   = (state_reg == ST_REPLAY);
    assign retry_err_o       = retry_err_reg;
    assign occupancy_o       = count_reg;

`ifdef DLL_REPLAY_STATS_EN
    logic [15:0] replay_count_reg;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            replay_count_reg <= '0;
        else if (start_replay && count_reg != '0 && replay_count_reg != 16'hFFFF)
            replay_count_reg <= replay_count_reg + 16'd1;
    end
    assign replay_count_o = replay_count_reg;
`endif

endmodule

// File: tb/tb_dll_replay_buffer.sv
// Directed bench for dll_replay_buffer: ACK purge, NAK replay, timeout replays, full buffer, seq wrap, overflow, reset.
module tb_dll_replay_buffer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = 4'hF;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [0:0]  s_axis_tuser = 1'b0;
    logic        s_axis_tready;
    logic [11:0] tx_seq_num_i = '0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic        m_axis_tready = 1'b1;
    logic        ack_nack_vld_i = 1'b0;
    logic        ack_nack_i = 1'b0;
    logic [11:0] ack_seq_num_i = '0;
    logic        retry_available_o, replay_active_o, retry_err_o;
    logic [2:0]  occupancy_o;

    dll_replay_buffer dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .tx_seq_num_i(tx_seq_num_i),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .ack_nack_vld_i(ack_nack_vld_i), .ack_nack_i(ack_nack_i), .ack_seq_num_i(ack_seq_num_i),
        .retry_available_o(retry_available_o), .replay_active_o(replay_active_o),
        .retry_err_o(retry_err_o), .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rep_data_q[$];
    logic        rep_last_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] mk_word(input logic [11:0] seq, input int w);
        return {4'hA, seq, 8'h00, 8'(w)};
    endfunction

    // Record every replayed beat that handshakes.
    always @(negedge clk) begin
        if (!rst_i && m_axis_tvalid && m_axis_tready && replay_active_o) begin
            rep_data_q.push_back(m_axis_tdata);
            rep_last_q.push_back(m_axis_tlast);
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        s_axis_tvalid = 1'b0;
        ack_nack_vld_i = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        rep_data_q.delete();
        rep_last_q.delete();
    endtask

    task automatic send_tlp(input logic [11:0] seq, input int n, input bit chk);
        int waited;
        for (int w = 0; w < n; w++) begin
            s_axis_tdata  = mk_word(seq, w);
            s_axis_tlast  = (w == n - 1);
            s_axis_tvalid = 1'b1;
            tx_seq_num_i  = seq;
            waited = 0;
            @(negedge clk);
            while (!s_axis_tready && waited < 300) begin
                @(negedge clk);
                waited++;
            end
            if (!s_axis_tready) begin
                check_val("s_tready_wait", 32'(s_axis_tready), 32'd1);
                @(posedge clk);
                #1;
                break;
            end
            if (chk && w == 0) begin
                check_val("fwd_tvalid", 32'(m_axis_tvalid), 32'd1);
                check_val("fwd_tdata", m_axis_tdata, mk_word(seq, 0));
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_ack(input logic is_ack, input logic [11:0] seq);
        ack_nack_vld_i = 1'b1;
        ack_nack_i     = is_ack;
        ack_seq_num_i  = seq;
        @(posedge clk);
        #1;
        ack_nack_vld_i = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for a whole replay; cyc returns negedges until replay_active_o was seen.
    task automatic wait_replay(input int limit, output int cyc);
        int d;
        cyc = 0;
        while (!replay_active_o && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (!replay_active_o) begin
            check_val("replay_start_bound", 32'(replay_active_o), 32'd1);
        end else begin
            d = 0;
            while (replay_active_o && d < limit) begin
                @(negedge clk);
                d++;
            end
            if (replay_active_o) check_val("replay_end_bound", 32'(replay_active_o), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        // Reset state
        do_reset();
        @(negedge clk);
        check_val("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("rst_retry_avail", 32'(retry_available_o), 32'd1);
        check_val("rst_replay_active", 32'(replay_active_o), 32'd0);
        check_val("rst_occupancy", 32'(occupancy_o), 32'd0);
        check_val("rst_retry_err", 32'(retry_err_o), 32'd0);
        @(posedge clk); #1;

        // Four TLPs, ACK seq 1 frees two
        for (int s = 0; s < 4; s++) send_tlp(12'(s), 8, s == 0);
        @(negedge clk);
        check_val("t1_occ_full", 32'(occupancy_o), 32'd4);
        @(posedge clk); #1;
        send_ack(1'b1, 12'd1);
        wait_cycles(5);
        @(negedge clk);
        check_val("t1_occ_after_ack", 32'(occupancy_o), 32'd2);
        check_val("t1_no_replay", 32'(rep_data_q.size()), 32'd0);
        @(posedge clk); #1;

        // Full buffer back-pressures; ACK of newest frees one slot per cycle
        do_reset();
        for (int s = 0; s < 4; s++) send_tlp(12'(s), 2, 1'b0);
        @(negedge clk);
        check_val("t2_tready_full", 32'(s_axis_tready), 32'd0);
        check_val("t2_avail_full", 32'(retry_available_o), 32'd0);
        @(posedge clk); #1;
        send_ack(1'b1, 12'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val($sformatf("t2_occ_step%0d", k), 32'(occupancy_o), 32'(4 - k));
        end
        check_val("t2_tready_back", 32'(s_axis_tready), 32'd1);
        check_val("t2_avail_back", 32'(retry_available_o), 32'd1);
        @(posedge clk); #1;

        // NAK seq 10: slot 10 freed, seq 11 replayed once
        do_reset();
        send_tlp(12'd10, 8, 1'b0);
        send_tlp(12'd11, 8, 1'b0);
        send_ack(1'b0, 12'd10);
        wait_replay(400, cyc);
        wait_cycles(20);
        check_val("t3_replay_words", 32'(rep_data_q.size()), 32'd8);
        for (int w = 0; w < 8 && w < rep_data_q.size(); w++) begin
            check_val($sformatf("t3_data%0d", w), rep_data_q[w], mk_word(12'd11, w));
            check_val($sformatf("t3_last%0d", w), 32'(rep_last_q[w]), 32'(w == 7));
        end
        check_val("t3_occ", 32'(occupancy_o), 32'd1);
        check_val("t3_retry_err", 32'(retry_err_o), 32'd0);

        // Timeout replays; fourth sets retry_err_o
        do_reset();
        send_tlp(12'd5, 4, 1'b0);
        wait_replay(400, cyc);
        check_val("t4_timeout_window", 32'(cyc >= 160 && cyc <= 165), 32'd1);
        check_val("t4_first_words", 32'(rep_data_q.size()), 32'd4);
        if (rep_data_q.size() >= 4) begin
            check_val("t4_data0", rep_data_q[0], mk_word(12'd5, 0));
            check_val("t4_last3", 32'(rep_last_q[3]), 32'd1);
        end
        wait_replay(400, cyc);
        wait_replay(400, cyc);
        check_val("t4_err_after3", 32'(retry_err_o), 32'd0);
        wait_replay(400, cyc);
        check_val("t4_err_after4", 32'(retry_err_o), 32'd1);
        check_val("t4_total_words", 32'(rep_data_q.size()), 32'd16);
        check_val("t4_occ", 32'(occupancy_o), 32'd1);

        // Sequence wrap 4094,4095,0 and NAK on empty buffer
        do_reset();
        send_tlp(12'd4094, 2, 1'b0);
        send_tlp(12'd4095, 2, 1'b0);
        send_tlp(12'd0, 2, 1'b0);
        send_ack(1'b1, 12'd4094);
        wait_cycles(4);
        @(negedge clk);
        check_val("t5_occ_partial", 32'(occupancy_o), 32'd2);
        @(posedge clk); #1;
        send_ack(1'b1, 12'd0);
        wait_cycles(4);
        @(negedge clk);
        check_val("t5_occ_wrap", 32'(occupancy_o), 32'd0);
        @(posedge clk); #1;
        send_ack(1'b0, 12'd0);
        wait_cycles(10);
        @(negedge clk);
        check_val("t5_empty_nak_active", 32'(replay_active_o), 32'd0);
        check_val("t5_empty_nak_words", 32'(rep_data_q.size()), 32'd0);
        @(posedge clk); #1;

        // Oversized TLP, full replay of stored words, then reset mid-replay
        do_reset();
        send_tlp(12'd7, 70, 1'b0);
        @(negedge clk);
        check_val("t6_overflow_err", 32'(retry_err_o), 32'd1);
        check_val("t6_occ", 32'(occupancy_o), 32'd1);
        @(posedge clk); #1;
        send_ack(1'b0, 12'd6);
        wait_replay(400, cyc);
        check_val("t6_replay_words", 32'(rep_data_q.size()), 32'd64);
        if (rep_data_q.size() >= 64) begin
            check_val("t6_data63", rep_data_q[63], mk_word(12'd7, 63));
            check_val("t6_last63", 32'(rep_last_q[63]), 32'd1);
            check_val("t6_last62", 32'(rep_last_q[62]), 32'd0);
        end
        send_ack(1'b0, 12'd6);
        cyc = 0;
        while (!replay_active_o && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        check_val("t6_mid_replay_active", 32'(replay_active_o), 32'd1);
        check_val("t6_mid_replay_tvalid", 32'(m_axis_tvalid), 32'd1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_val("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("t6_rst_occ", 32'(occupancy_o), 32'd0);
        check_val("t6_rst_err", 32'(retry_err_o), 32'd0);
        check_val("t6_rst_active", 32'(replay_active_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
